chan_err_sched: RTL and testbench

Channel error-injection scheduler for the convolutional-encoder to Viterbi-decoder link. It sits between the encoder's 2-bit symbol output and the decoder input. It passes symbols through a one-cycle register and, during a started frame, corrupts symbols on a programmable periodic burst schedule. It also counts the corrupted symbols and flipped bits so the bench can compare them against decoder output errors.

---
 rtl/chan_err_sched.sv | 214 +++++++++++++++++++++
 tb/tb_chan_err_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/chan_err_sched.sv
// chan_err_sched: channel error-injection scheduler between the convolutional
// encoder symbol output and the Viterbi decoder input.
// Symbols pass through a one-cycle register. During a started frame, the first
// BURST valid symbols of every PERIOD-symbol window are XOR-corrupted. The block
// counts corrupted symbols, flipped bits and consumed symbols.
//
// Optional feature: define CHAN_ERR_LFSR_EN to take masks from a 16-bit
// Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1). When it is not defined,
// masks follow the fixed rotation 11 -> 10 -> 01 -> 11 and no LFSR is built.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | pure pass-through, waiting for start_i
// PASS    | in frame, the next valid symbol passes clean
// CORRUPT | in frame, the next valid symbol is corrupted (ph < BURST)
// DONE    | one cycle, done_o high, then IDLE
module chan_err_sched #(
  parameter int PERIOD = 16,
  parameter int BURST  = 1,
  parameter int FRAME  = 256,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [1:0]    sym_i,
  input  logic          sym_valid_i,
  output logic [1:0]    sym_o,
  output logic          sym_valid_o,
  output logic [1:0]    err_mask_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] err_ct_o,
  output logic [CW-1:0] bit_ct_o,
  output logic [CW-1:0] sym_ct_o
);

  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  // One extra bit so BURST == PERIOD == 2**PW still compares correctly.
  localparam logic [PW:0]   BURST_W = (PW+1)'(BURST);
  localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);
  localparam logic [CW-1:0] FRAME_W = CW'(FRAME);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_CORRUPT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [1:0]    sym_q, sym_d;
  logic          valid_q, valid_d;
  logic [1:0]    mask_q, mask_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] err_ct_q, err_ct_d;
  logic [CW-1:0] bit_ct_q, bit_ct_d;
  logic [CW-1:0] sym_ct_q, sym_ct_d;
  logic [1:0]    cur_mask;
  logic          gen_step;
  logic          gen_seed;

  // Saturating add of a small increment; counters stick at all-ones.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-1){1'b0}}, b};
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

`ifdef CHAN_ERR_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Map the LFSR low bits onto a non-zero mask so every burst symbol is hit.
  always_comb begin
    case (lfsr_q[1:0])
      2'b00:   cur_mask = 2'b11;
      2'b01:   cur_mask = 2'b10;
      2'b10:   cur_mask = 2'b01;
      default: cur_mask = 2'b11;
    endcase
  end

  // LFSR next value: re-seed on frame start, step once per corrupted symbol.
  always_comb begin
    lfsr_d = lfsr_q;
    if (gen_seed) begin
      lfsr_d = 16'hACE1;
    end else if (gen_step) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Mask generator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end
`else
  logic [1:0] rot_q, rot_d;

  assign cur_mask = rot_q;

  // Rotation next value: re-seed on frame start, advance per corrupted symbol.
  always_comb begin
    rot_d = rot_q;
    if (gen_seed) begin
      rot_d = 2'b11;
    end else if (gen_step) begin
      case (rot_q)
        2'b11:   rot_d = 2'b10;
        2'b10:   rot_d = 2'b01;
        default: rot_d = 2'b11;
      endcase
    end
  end

  // Mask generator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rot_q <= 2'b11;
    else      rot_q <= rot_d;
  end
`endif

  // Next-state, datapath and counter logic for one cycle.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    err_ct_d = err_ct_q;
    bit_ct_d = bit_ct_q;
    sym_ct_d = sym_ct_q;
    sym_d    = sym_valid_i ? sym_i : sym_q;
    valid_d  = sym_valid_i;
    mask_d   = 2'b00;
    gen_step = 1'b0;
    gen_seed = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_ct_d = '0;
          bit_ct_d = '0;
          sym_ct_d = '0;
          ph_d     = '0;
          gen_seed = 1'b1;
          state_d  = (BURST > 0) ? S_CORRUPT : S_PASS;
        end
      end
      S_PASS, S_CORRUPT: begin
        if (abort_i) begin
          // Aborted symbol still counts as consumed but is never corrupted.
          state_d = S_IDLE;
          if (sym_valid_i) sym_ct_d = sat_add(sym_ct_q, 2'd1);
        end else if (sym_valid_i) begin
          sym_ct_d = sat_add(sym_ct_q, 2'd1);
          ph_d     = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
          if (state_q == S_CORRUPT) begin
            mask_d   = cur_mask;
            sym_d    = sym_i ^ cur_mask;
            gen_step = 1'b1;
            err_ct_d = sat_add(err_ct_q, 2'd1);
            bit_ct_d = sat_add(bit_ct_q, {1'b0, cur_mask[1]} + {1'b0, cur_mask[0]});
          end
          if (sym_ct_d == FRAME_W) state_d = S_DONE;
          else if ({1'b0, ph_d} < BURST_W) state_d = S_CORRUPT;
          else state_d = S_PASS;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_PASS) || (state_d == S_CORRUPT);
    done_d = (state_d == S_DONE);
  end

  // State, registered outputs and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ph_q     <= '0;
      sym_q    <= 2'b00;
      valid_q  <= 1'b0;
      mask_q   <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_ct_q <= '0;
      bit_ct_q <= '0;
      sym_ct_q <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      sym_q    <= sym_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_ct_q <= err_ct_d;
      bit_ct_q <= bit_ct_d;
      sym_ct_q <= sym_ct_d;
    end
  end

  assign sym_o       = sym_q;
  assign sym_valid_o = valid_q;
  assign err_mask_o  = mask_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_ct_o    = err_ct_q;
  assign bit_ct_o    = bit_ct_q;
  assign sym_ct_o    = sym_ct_q;

endmodule

// File: tb/tb_chan_err_sched.sv
// Bench for chan_err_sched: three parameterisations driven by the same
// stimulus, each checked every cycle against an index-based frame model.
module tb_chan_err_sched;

  localparam int N = 3;
  localparam int P[N] = '{16, 8, 16};
  localparam int B[N] = '{1, 3, 0};
  localparam int F[N] = '{256, 16, 256};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0, abort_i = 1'b0, sym_valid_i = 1'b0;
  logic [1:0] sym_i = 2'b00;

  logic [1:0]  so[N];
  logic        sv[N];
  logic [1:0]  sm[N];
  logic        bz[N];
  logic        dn[N];
  logic [15:0] ec_o[N];
  logic [15:0] bc_o[N];
  logic [15:0] sc_o[N];

  int errors = 0;
  int checks = 0;
  int done_cnt0 = 0;

  // model state
  bit          in_fr[N];
  bit          done_n[N];
  int          k[N], ec[N], bc[N], nc[N];
  logic [15:0] lf[N];
  logic [1:0]  prev[N];
  logic [1:0]  e_mask[N];
  bit          e_val[N];

  always #5 clk = ~clk;

  chan_err_sched #(.PERIOD(16), .BURST(1), .FRAME(256), .CW(16)) u0 (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .sym_i(sym_i), .sym_valid_i(sym_valid_i), .sym_o(so[0]), .sym_valid_o(sv[0]),
    .err_mask_o(sm[0]), .busy_o(bz[0]), .done_o(dn[0]),
    .err_ct_o(ec_o[0]), .bit_ct_o(bc_o[0]), .sym_ct_o(sc_o[0]));

  chan_err_sched #(.PERIOD(8), .BURST(3), .FRAME(16), .CW(16)) u1 (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .sym_i(sym_i), .sym_valid_i(sym_valid_i), .sym_o(so[1]), .sym_valid_o(sv[1]),
    .err_mask_o(sm[1]), .busy_o(bz[1]), .done_o(dn[1]),
    .err_ct_o(ec_o[1]), .bit_ct_o(bc_o[1]), .sym_ct_o(sc_o[1]));

  chan_err_sched #(.PERIOD(16), .BURST(0), .FRAME(256), .CW(16)) u2 (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .sym_i(sym_i), .sym_valid_i(sym_valid_i), .sym_o(so[2]), .sym_valid_o(sv[2]),
    .err_mask_o(sm[2]), .busy_o(bz[2]), .done_o(dn[2]),
    .err_ct_o(ec_o[2]), .bit_ct_o(bc_o[2]), .sym_ct_o(sc_o[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mask of the n-th corruption in the frame for the given LFSR value.
  function automatic logic [1:0] gen_mask(input int n, input logic [15:0] l);
`ifdef CHAN_ERR_LFSR_EN
    int lo;
    lo = int'(l) % 4;
    return (lo == 0) ? 2'b11 : (lo == 1) ? 2'b10 : (lo == 2) ? 2'b01 : 2'b11;
`else
    return (n % 3 == 0) ? 2'b11 : (n % 3 == 1) ? 2'b10 : 2'b01;
`endif
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    int v, fb;
    v  = int'(l);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'((v * 2 + fb) % 65536);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      in_fr[i] = 0; done_n[i] = 0;
      k[i] = 0; ec[i] = 0; bc[i] = 0; nc[i] = 0;
      lf[i] = 16'hACE1; prev[i] = 2'b00; e_mask[i] = 2'b00; e_val[i] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_cycle();
    for (int i = 0; i < N; i++) begin
      logic [1:0] m;
      bit done_now;
      m = 2'b00;
      done_now = done_n[i];
      done_n[i] = 0;
      if (in_fr[i]) begin
        if (abort_i) begin
          in_fr[i] = 0;
          if (sym_valid_i) k[i]++;
        end else if (sym_valid_i) begin
          if ((k[i] % P[i]) < B[i]) begin
            m = gen_mask(nc[i], lf[i]);
            ec[i]++;
            bc[i] += int'(m[0]) + int'(m[1]);
            nc[i]++;
            lf[i] = lfsr_next(lf[i]);
          end
          k[i]++;
          if (k[i] == F[i]) begin
            in_fr[i] = 0;
            done_n[i] = 1;
          end
        end
      end else if (!done_now && start_i) begin
        in_fr[i] = 1;
        k[i] = 0; ec[i] = 0; bc[i] = 0; nc[i] = 0;
        lf[i] = 16'hACE1;
      end
      e_val[i]  = sym_valid_i;
      e_mask[i] = m;
      if (sym_valid_i) prev[i] = sym_i ^ m;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("d%0d sym_o", i), so[i], prev[i]);
      chk($sformatf("d%0d sym_valid_o", i), sv[i], e_val[i]);
      chk($sformatf("d%0d err_mask_o", i), sm[i], e_mask[i]);
      chk($sformatf("d%0d busy_o", i), bz[i], in_fr[i]);
      chk($sformatf("d%0d done_o", i), dn[i], done_n[i]);
      chk($sformatf("d%0d err_ct", i), ec_o[i], ec[i]);
      chk($sformatf("d%0d bit_ct", i), bc_o[i], bc[i]);
      chk($sformatf("d%0d sym_ct", i), sc_o[i], k[i]);
    end
    if (dn[0] === 1'b1) done_cnt0++;
  endtask

  task automatic step(input bit st, input bit ab, input bit v, input logic [1:0] s);
    start_i = st; abort_i = ab; sym_valid_i = v; sym_i = s;
    model_cycle();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset between edges, checked before the next edge arrives.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // all-zero frame, every cycle valid
    done_cnt0 = 0;
    step(1, 0, 0, 2'b00);
    for (int j = 0; j < 262; j++) step(0, 0, 1, 2'b00);
    chk("t1 err_ct", ec_o[0], 16);
    chk("t1 bit_ct", bc_o[0], 22);
    chk("t1 sym_ct", sc_o[0], 256);
    chk("t1 done pulses", done_cnt0, 1);
    chk("t1 busy after", bz[0], 0);
    chk("t1 burst0 err_ct", ec_o[2], 0);

    // valid every other cycle, random symbols
    step(1, 0, 0, 2'b00);
    for (int j = 0; j < 34; j++) step(0, 0, (j % 2) == 0, 2'($urandom));
    chk("t2 err_ct p8b3", ec_o[1], 6);
    chk("t2 sym_ct p8b3", sc_o[1], 16);
    for (int j = 0; j < 300; j++) step(0, 0, 1, 2'($urandom));

    // abort at valid index 20
    done_cnt0 = 0;
    step(1, 0, 0, 2'b00);
    for (int j = 0; j < 20; j++) step(0, 0, 1, 2'($urandom));
    step(0, 1, 1, 2'b01);
    chk("t3 err_ct", ec_o[0], 2);
    chk("t3 sym_ct", sc_o[0], 21);
    chk("t3 busy", bz[0], 0);
    for (int j = 0; j < 10; j++) step(0, 0, 1, 2'($urandom));
    chk("t3 no done", done_cnt0, 0);

    // reset mid-frame at index 100, then a full clean frame
    step(1, 0, 0, 2'b00);
    for (int j = 0; j < 100; j++) step(0, 0, 1, 2'($urandom));
    async_reset();
    chk("t4 reset err_ct", ec_o[0], 0);
    step(1, 0, 0, 2'b00);
    for (int j = 0; j < 258; j++) step(0, 0, 1, 2'($urandom));
    chk("t4 err_ct", ec_o[0], 16);

    // start re-pulsed mid-frame is ignored
    done_cnt0 = 0;
    step(1, 0, 0, 2'b00);
    for (int j = 0; j < 258; j++) step((j % 37) == 5, 0, 1, 2'($urandom));
    chk("t5 sym_ct", sc_o[0], 256);
    chk("t5 done pulses", done_cnt0, 1);

    // two back-to-back frames (identical mask sequences via re-seed)
    for (int f = 0; f < 2; f++) begin
      step(1, 0, 0, 2'b00);
      for (int j = 0; j < 257; j++) step(0, 0, 1, 2'($urandom));
    end

    // random traffic with occasional starts and aborts
    for (int j = 0; j < 2500; j++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 3) != 0, 2'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
